// File: rtl/fp29i_to_fp16_pack_if.sv
// Handshake bundle for the FP29i -> FP16 output formatter.
// master drives words in and accepts results; slave is the formatter.
interface fp29i_to_fp16_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sgn;
    logic [5:0]  in_exp;
    logic [21:0] in_man_dn;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_fp16;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inx;

    modport master (
        output in_valid, in_sgn, in_exp, in_man_dn, out_ready,
        input  in_ready, out_valid, out_fp16, out_ovf, out_unf, out_inx
    );

    modport slave (
        input  in_valid, in_sgn, in_exp, in_man_dn, out_ready,
        output in_ready, out_valid, out_fp16, out_ovf, out_unf, out_inx
    );
endinterface

// File: rtl/fp29i_to_fp16_pack.sv
// Renormalizes an FP29i word (sign, 6-bit exp, right-aligned 22-bit mantissa)
// and rounds it to IEEE FP16 with round-to-nearest-even; one word in flight.
//
// state | meaning
// IDLE  | waiting for an input word, in_ready high
// NORM  | leading-zero count and left-justify of the mantissa
// RND   | denormalize/round/overflow handling, result registered
// OUT   | result held until out_ready
module fp29i_to_fp16_pack #(
    parameter bit SAT_INF = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    fp29i_to_fp16_pack_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] RND  = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]         state_q;
    logic               sgn_q;
    logic [5:0]         exp_q;
    logic [21:0]        man_q;
    logic               zero_q;
    logic signed [7:0]  e_q;
    logic [21:0]        sig_q;
    logic               out_valid_q;
    logic [15:0]        out_fp16_q;
    logic               ovf_q, unf_q, inx_q;

    logic [4:0]         lz_d;
    logic signed [7:0]  e_d;
    logic [21:0]        sig_d;

    always_comb begin
        lz_d = 5'd0;
        for (int i = 0; i < 22; i++) begin
            if (man_q[i]) lz_d = 5'(21 - i);
        end
        e_d   = $signed({2'b00, exp_q}) - 8'sd16 - $signed({3'b000, lz_d});
        sig_d = man_q << lz_d;
    end

    logic signed [7:0]  sh_full;
    logic [4:0]         sh_amt;
    logic [21:0]        sig_sh;
    logic               lost;
    logic [9:0]         frac;
    logic               guard, sticky, round_up;
    logic [4:0]         exp_fld;
    logic [14:0]        rounded;
    logic [15:0]        res_d;
    logic               ovf_d, unf_d, inx_d;

    always_comb begin
        sh_full  = 8'sd1 - e_q;
        sh_amt   = 5'd0;
        if (e_q <= 8'sd0) sh_amt = (sh_full > 8'sd12) ? 5'd12 : sh_full[4:0];
        // bits pushed below the result are only ever needed for sticky
        sig_sh   = sig_q >> sh_amt;
        lost     = |(sig_q & ((22'd1 << sh_amt) - 22'd1));
        frac     = sig_sh[20:11];
        guard    = sig_sh[10];
        sticky   = (|sig_sh[9:0]) | lost;
        round_up = guard & (sticky | frac[0]);
        exp_fld  = (e_q >= 8'sd1) ? e_q[4:0] : 5'd0;
        rounded  = {exp_fld, frac} + {14'd0, round_up};

        res_d = {sgn_q, 15'd0};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = 1'b0;
        if (zero_q) begin
            res_d = {sgn_q, 15'd0};
        end else if (e_q >= 8'sd31) begin
            res_d = {sgn_q, SAT_INF ? 15'h7C00 : 15'h7BFF};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else begin
            ovf_d = (rounded[14:10] == 5'h1F);
            res_d = {sgn_q, (ovf_d && !SAT_INF) ? 15'h7BFF : rounded};
            inx_d = guard | sticky;
            unf_d = inx_d & (exp_fld == 5'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sgn_q       <= 1'b0;
            exp_q       <= 6'd0;
            man_q       <= 22'd0;
            zero_q      <= 1'b0;
            e_q         <= 8'sd0;
            sig_q       <= 22'd0;
            out_valid_q <= 1'b0;
            out_fp16_q  <= 16'd0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    sgn_q   <= bus.in_sgn;
                    exp_q   <= bus.in_exp;
                    man_q   <= bus.in_man_dn;
                    state_q <= NORM;
                end
                NORM: begin
                    zero_q  <= (man_q == 22'd0);
                    e_q     <= e_d;
                    sig_q   <= sig_d;
                    state_q <= RND;
                end
                RND: begin
                    out_fp16_q  <= res_d;
                    ovf_q       <= ovf_d;
                    unf_q       <= unf_d;
                    inx_q       <= inx_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                default: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_fp16  = out_fp16_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_unf   = unf_q;
    assign bus.out_inx   = inx_q;
endmodule

// File: tb/tb_fp29i_to_fp16_pack.sv
// Bench for fp29i_to_fp16_pack: directed and random words into an infinity
// and a saturating instance, compared with an arithmetic FP16 rounding model.
module tb_fp29i_to_fp16_pack;
    localparam int N = 60;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_sgn, out_ready;
    logic [5:0]  in_exp;
    logic [21:0] in_man_dn;

    fp29i_to_fp16_pack_if bus_i ();
    fp29i_to_fp16_pack_if bus_s ();

    assign bus_i.in_valid = in_valid;  assign bus_s.in_valid = in_valid;
    assign bus_i.in_sgn = in_sgn;      assign bus_s.in_sgn = in_sgn;
    assign bus_i.in_exp = in_exp;      assign bus_s.in_exp = in_exp;
    assign bus_i.in_man_dn = in_man_dn; assign bus_s.in_man_dn = in_man_dn;
    assign bus_i.out_ready = out_ready; assign bus_s.out_ready = out_ready;

    fp29i_to_fp16_pack #(.SAT_INF(1'b1)) dut_inf (.clk(clk), .rst_n(rst_n), .bus(bus_i));
    fp29i_to_fp16_pack #(.SAT_INF(1'b0)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {ovf, unf, inx, fp16} from value = (-1)^s * m * 2^(e-52), rounded to nearest even
    function automatic logic [18:0] ref_model(input bit s, input int e, input int m, input bit sat);
        int p, b, k, sh, res;
        longint n, rem, half;
        bit ovf, unf, inx;
        if (m == 0) return {3'b000, s, 15'd0};
        p = 21;
        while (!m[p]) p--;
        b = p + e - 37;
        if (b >= 31) begin
            res = sat ? 32'h7C00 : 32'h7BFF;
            ovf = 1'b1; inx = 1'b1; unf = 1'b0;
        end else begin
            k  = (b >= 1) ? b - 25 : -24;
            sh = (e - 52) - k;
            if (sh >= 0) begin
                n = longint'(m) <<< sh; rem = 0; half = 1;
            end else begin
                n    = longint'(m) >>> (-sh);
                rem  = longint'(m) & ((64'sd1 <<< (-sh)) - 1);
                half = 64'sd1 <<< (-sh - 1);
            end
            inx = (rem != 0);
            if (rem > half || (rem == half && n[0])) n++;
            res = (b >= 1) ? ((b - 1) << 10) + int'(n) : int'(n);
            ovf = (res >= 32'h7C00);
            if (ovf && sat) res = 32'h7C00;
            if (ovf && !sat) res = 32'h7BFF;
            unf = inx && (b <= 0);
        end
        return {ovf, unf, inx, s, res[14:0]};
    endfunction

    bit          s_a [N+1];
    logic [5:0]  e_a [N+1];
    logic [21:0] m_a [N+1];
    int          st_a[N+1];

    task automatic add(input int i, input bit s, input logic [5:0] e, input logic [21:0] m, input int st);
        s_a[i] = s; e_a[i] = e; m_a[i] = m; st_a[i] = st;
    endtask

    task automatic drive_word(input int i);
        in_sgn = s_a[i]; in_exp = e_a[i]; in_man_dn = m_a[i];
    endtask

    task automatic chk_result(input string tag, input logic [18:0] ei, input logic [18:0] es);
        chk({tag, "_fp16_inf"}, {16'd0, bus_i.out_fp16}, {16'd0, ei[15:0]});
        chk({tag, "_flags_inf"}, {29'd0, bus_i.out_ovf, bus_i.out_unf, bus_i.out_inx}, {29'd0, ei[18:16]});
        chk({tag, "_fp16_sat"}, {16'd0, bus_s.out_fp16}, {16'd0, es[15:0]});
        chk({tag, "_flags_sat"}, {29'd0, bus_s.out_ovf, bus_s.out_unf, bus_s.out_inx}, {29'd0, es[18:16]});
    endtask

    // Entered and left at a falling edge; word i+1 is held valid throughout so it must be ignored until IDLE
    task automatic txn(input int i);
        logic [18:0] ei, es;
        ei = ref_model(s_a[i], int'(e_a[i]), int'(m_a[i]), 1'b1);
        es = ref_model(s_a[i], int'(e_a[i]), int'(m_a[i]), 1'b0);
        drive_word(i);
        in_valid = 1'b1;
        out_ready = 1'b0;
        chk("in_ready_idle", {31'd0, bus_i.in_ready & bus_s.in_ready}, 32'd1);
        @(posedge clk);
        #1 drive_word(i + 1);
        @(negedge clk);
        chk("busy_norm", {30'd0, bus_i.in_ready | bus_s.in_ready, bus_i.out_valid | bus_s.out_valid}, 32'd0);
        @(negedge clk);
        chk("busy_rnd", {30'd0, bus_i.in_ready | bus_s.in_ready, bus_i.out_valid | bus_s.out_valid}, 32'd0);
        @(negedge clk);
        chk("out_valid_rise", {30'd0, bus_i.out_valid, bus_s.out_valid}, 32'd3);
        chk_result("res", ei, es);
        for (int c = 0; c < st_a[i]; c++) begin
            @(negedge clk);
            chk("stall_hold", {29'd0, bus_i.out_valid, bus_s.out_valid, bus_i.in_ready}, 32'd6);
            chk_result("stall", ei, es);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("handoff", {29'd0, bus_i.out_valid, bus_s.out_valid, bus_i.in_ready & bus_s.in_ready}, 32'd1);
        chk("retain_fp16", {16'd0, bus_i.out_fp16}, {16'd0, ei[15:0]});
    endtask

    initial begin
        int k;
        logic [18:0] dummy;
        in_valid = 1'b0; in_sgn = 1'b0; in_exp = 6'd0; in_man_dn = 22'd0; out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, bus_i.in_ready & bus_s.in_ready}, 32'd1);
        chk("rst_out", {12'd0, bus_i.out_valid, bus_i.out_ovf, bus_i.out_unf, bus_i.out_inx, bus_i.out_fp16}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        add(0,  0, 6'd31, 22'h200000, 5);
        add(1,  0, 6'd31, 22'h000001, 0);
        add(2,  0, 6'd0,  22'h000001, 1);
        add(3,  0, 6'd31, 22'h200800, 0);
        add(4,  0, 6'd31, 22'h200400, 0);
        add(5,  0, 6'd31, 22'h200C00, 2);
        add(6,  0, 6'd31, 22'h3FFFFF, 0);
        add(7,  0, 6'd63, 22'h200000, 0);
        add(8,  1, 6'd63, 22'h200000, 1);
        add(9,  1, 6'd40, 22'h000000, 0);
        add(10, 0, 6'd40, 22'h000000, 0);
        add(11, 0, 6'd46, 22'h3FFFFF, 0);
        add(12, 1, 6'd46, 22'h3FFFFE, 0);
        add(13, 0, 6'd16, 22'h3FF800, 0);
        add(14, 0, 6'd5,  22'h000C00, 0);
        for (int i = 15; i <= N; i++) begin
            k = int'($urandom_range(0, 21));
            add(i, 1'($urandom), 6'($urandom_range(0, 63)),
                ($urandom_range(0, 7) == 0) ? 22'd0 : (22'($urandom) >> k), int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < N; i++) txn(i);
        in_valid = 1'b0;

        // abort a word in NORM with an asynchronous reset
        @(negedge clk);
        drive_word(1);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("abort_rst", {14'd0, bus_i.out_valid, bus_i.in_ready, bus_i.out_fp16}, 32'h10000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_idle", {30'd0, bus_i.out_valid | bus_s.out_valid, bus_i.in_ready & bus_s.in_ready}, 32'd1);
        end
        dummy = 19'd0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
